// File: rtl/peg_l2_rmii_rx_if.sv
// Received byte stream from the RMII deframer towards the L2 header parser and FCS consumer.
// Error flags are meaningful only on the rx_eop beat.
interface peg_l2_rmii_rx_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_sop;
  logic       rx_eop;
  logic       rx_err_crc;
  logic       rx_err_runt;
  logic       rx_err_giant;
  logic       rx_err_align;

  modport master (
    output rx_valid,
    output rx_data,
    output rx_sop,
    output rx_eop,
    output rx_err_crc,
    output rx_err_runt,
    output rx_err_giant,
    output rx_err_align
  );

  modport slave (
    input rx_valid,
    input rx_data,
    input rx_sop,
    input rx_eop,
    input rx_err_crc,
    input rx_err_runt,
    input rx_err_giant,
    input rx_err_align
  );
endinterface

// File: rtl/peg_l2_rmii_rx.sv
// RMII receive deframer: strips preamble/SFD, packs di-bits into bytes and flags
// CRC, runt, giant and alignment errors on the last byte of each frame.
module peg_l2_rmii_rx #(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1522
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             speed_100,
  input  logic             rmii_crs_dv,
  input  logic [1:0]       rmii_rxd,
  peg_l2_rmii_rx_if.master rx
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_BYTES   = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_BYTES   = 11'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        crs_q;
  logic        crs_rise;
  logic        sample_en;
  logic [3:0]  div_cnt;

  logic        seen_pre;
  logic [1:0]  dibit_cnt;
  logic [5:0]  shreg;
  logic [7:0]  new_byte;
  logic [7:0]  held;
  logic        have_held;
  logic        sop_pend;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic        byte_done;

  logic        pre_clr;
  logic        pre_set;
  logic        sfd;
  logic        shift;
  logic        commit;
  logic        emit;
  logic        last;
  logic        giant;

  function automatic logic [31:0] crc_dibit(input logic [31:0] crc_in, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < 2; i++) begin
      c = (c >> 1) ^ ((c[0] ^ dibit[i]) ? CRC_POLY : '0);
    end
    return c;
  endfunction

  // At 10 Mb/s the divider is re-phased on carrier rise so each di-bit is
  // sampled at the same offset inside its 10-cycle window.
  always_comb begin
    crs_rise  = rmii_crs_dv & ~crs_q;
    sample_en = speed_100 | crs_rise | (div_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crs_q   <= 1'b0;
      div_cnt <= '0;
    end else begin
      crs_q <= rmii_crs_dv;
      if (crs_rise) begin
        div_cnt <= 4'd1;
      end else if (div_cnt == 4'd9) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    new_byte  = {rmii_rxd, shreg};
    byte_done = (dibit_cnt == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pre_clr   = 1'b0;
    pre_set   = 1'b0;
    sfd       = 1'b0;
    shift     = 1'b0;
    commit    = 1'b0;
    emit      = 1'b0;
    last      = 1'b0;
    giant     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_en && rmii_crs_dv) begin
          state_nxt = PREAMBLE;
          pre_clr   = 1'b1;
        end
      end
      PREAMBLE: begin
        if (sample_en) begin
          if (!rmii_crs_dv) begin
            state_nxt = IDLE;
          end else begin
            case (rmii_rxd)
              2'b01: pre_set = 1'b1;
              2'b11: begin
                if (seen_pre) begin
                  state_nxt = DATA;
                  sfd       = 1'b1;
                end else begin
                  state_nxt = DROP;
                end
              end
              2'b10:   state_nxt = DROP;
              default: ;
            endcase
          end
        end
      end
      DATA: begin
        if (sample_en) begin
          if (!rmii_crs_dv) begin
            // The held byte is the last one; nothing held means a zero-byte frame.
            state_nxt = IDLE;
            emit      = have_held;
            last      = 1'b1;
          end else begin
            shift = 1'b1;
            if (byte_done) begin
              if (byte_cnt >= MAX_BYTES) begin
                state_nxt = DROP;
                emit      = have_held;
                last      = 1'b1;
                giant     = 1'b1;
              end else begin
                commit = 1'b1;
                emit   = have_held;
              end
            end
          end
        end
      end
      DROP: begin
        if (sample_en && !rmii_crs_dv) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_pre        <= 1'b0;
      dibit_cnt       <= '0;
      shreg           <= '0;
      held            <= '0;
      have_held       <= 1'b0;
      sop_pend        <= 1'b0;
      byte_cnt        <= '0;
      crc             <= '1;
      rx.rx_valid     <= 1'b0;
      rx.rx_data      <= '0;
      rx.rx_sop       <= 1'b0;
      rx.rx_eop       <= 1'b0;
      rx.rx_err_crc   <= 1'b0;
      rx.rx_err_runt  <= 1'b0;
      rx.rx_err_giant <= 1'b0;
      rx.rx_err_align <= 1'b0;
    end else begin
      rx.rx_valid     <= 1'b0;
      rx.rx_sop       <= 1'b0;
      rx.rx_eop       <= 1'b0;
      rx.rx_err_crc   <= 1'b0;
      rx.rx_err_runt  <= 1'b0;
      rx.rx_err_giant <= 1'b0;
      rx.rx_err_align <= 1'b0;

      if (pre_clr) begin
        seen_pre <= 1'b0;
      end else if (pre_set) begin
        seen_pre <= 1'b1;
      end

      if (sfd) begin
        dibit_cnt <= '0;
        byte_cnt  <= '0;
        crc       <= '1;
        have_held <= 1'b0;
        sop_pend  <= 1'b1;
      end

      if (shift) begin
        shreg     <= {rmii_rxd, shreg[5:2]};
        dibit_cnt <= dibit_cnt + 2'd1;
        crc       <= crc_dibit(crc, rmii_rxd);
      end

      // One-byte hold delays output so the final byte can carry eop and status.
      if (commit) begin
        held      <= new_byte;
        have_held <= 1'b1;
        if (byte_cnt != '1) begin
          byte_cnt <= byte_cnt + 11'd1;
        end
      end

      if (last) begin
        have_held <= 1'b0;
      end

      if (emit) begin
        rx.rx_valid <= 1'b1;
        rx.rx_data  <= held;
        rx.rx_sop   <= sop_pend;
        rx.rx_eop   <= last;
        sop_pend    <= 1'b0;
        if (giant) begin
          rx.rx_err_giant <= 1'b1;
        end else if (last) begin
          rx.rx_err_align <= (dibit_cnt != '0);
          rx.rx_err_crc   <= (crc != CRC_RESIDUE);
          rx.rx_err_runt  <= (byte_cnt < MIN_BYTES);
        end
      end
    end
  end

endmodule

// File: tb/tb_peg_l2_rmii_rx.sv
// Randomized frame-level bench for peg_l2_rmii_rx with a byte-level reference model.
module tb_peg_l2_rmii_rx;
  localparam int unsigned MINB = 64;
  localparam int unsigned MAXB = 1522;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       crc;
    logic       runt;
    logic       giant;
    logic       align;
  } beat_t;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       speed_100 = 1'b1;
  logic       crs       = 1'b0;
  logic [1:0] rxd       = 2'b00;

  peg_l2_rmii_rx_if rx_if ();

  peg_l2_rmii_rx #(
    .MIN_FRAME_BYTES(MINB),
    .MAX_FRAME_BYTES(MAXB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .speed_100  (speed_100),
    .rmii_crs_dv(crs),
    .rmii_rxd   (rxd),
    .rx         (rx_if)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t       obs[$];
  int unsigned obs_cyc[$];
  beat_t       exp_q[$];
  logic [7:0]  frame[$];
  int unsigned total    = 0;
  int unsigned bad      = 0;
  int unsigned drop_cyc = 0;

  always @(negedge clk) begin
    if (rx_if.rx_valid === 1'b1) begin
      obs.push_back(beat_t'({rx_if.rx_data, rx_if.rx_sop, rx_if.rx_eop, rx_if.rx_err_crc,
                             rx_if.rx_err_runt, rx_if.rx_err_giant, rx_if.rx_err_align}));
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] crc_raw(input int unsigned len);
    logic [31:0] c;
    c = '1;
    for (int unsigned i = 0; i < len; i++) begin
      c = c ^ {24'h0, frame[i]};
      for (int unsigned k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [13:0] all_outputs();
    return {rx_if.rx_valid, rx_if.rx_data, rx_if.rx_sop, rx_if.rx_eop, rx_if.rx_err_crc,
            rx_if.rx_err_runt, rx_if.rx_err_giant, rx_if.rx_err_align};
  endfunction

  task automatic clear();
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  // n bytes including a 4-byte FCS; a corrupted byte is 0x00 when the FCS is computed, then 0x01.
  task automatic make_frame(input int unsigned n, input int corrupt);
    logic [31:0] fcs;
    frame.delete();
    for (int unsigned i = 0; i + 4 < n; i++) frame.push_back(8'($urandom));
    if (corrupt >= 0) frame[corrupt] = 8'h00;
    fcs = ~crc_raw(n - 4);
    for (int unsigned k = 0; k < 4; k++) frame.push_back(fcs[8*k +: 8]);
    if (corrupt >= 0) frame[corrupt] = 8'h01;
  endtask

  task automatic model(input int unsigned n, input int unsigned partial);
    int unsigned nb;
    logic        crc_bad;
    beat_t       b;
    if (n == 0) return;
    nb = (n > MAXB) ? MAXB : n;
    if (n >= 4) crc_bad = (crc_raw(n - 4) != ~{frame[n-1], frame[n-2], frame[n-3], frame[n-4]});
    else        crc_bad = (crc_raw(n) != 32'hDEBB20E3);
    for (int unsigned i = 0; i < nb; i++) begin
      b      = '0;
      b.data = frame[i];
      b.sop  = (i == 0);
      b.eop  = (i == nb - 1);
      if (b.eop) begin
        if (n > MAXB) begin
          b.giant = 1'b1;
        end else begin
          b.crc   = crc_bad;
          b.runt  = (n < MINB);
          b.align = (partial != 0);
        end
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic put(input logic c, input logic [1:0] d);
    crs = c;
    rxd = d;
    repeat (speed_100 ? 1 : 10) @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    for (int unsigned k = 0; k < 4; k++) put(1'b1, b[2*k +: 2]);
  endtask

  task automatic put_preamble();
    for (int unsigned i = 0; i < 7; i++) put_byte(8'h55);
    put_byte(8'hD5);
  endtask

  task automatic put_gap(input int unsigned g);
    drop_cyc = cyc + 1;
    for (int unsigned i = 0; i < g; i++) put(1'b0, 2'b00);
  endtask

  task automatic send(input int unsigned n, input int unsigned partial, input int unsigned gap);
    put_preamble();
    for (int unsigned i = 0; i < n; i++) put_byte(frame[i]);
    for (int unsigned p = 0; p < partial; p++) put(1'b1, 2'($urandom));
    put_gap(gap);
  endtask

  task automatic analyze(input beat_t mask, output int unsigned ndiff, output beat_t lb);
    ndiff = 0;
    for (int unsigned i = 0; i < obs.size() && i < exp_q.size(); i++)
      if (((obs[i] ^ exp_q[i]) & mask) != '0) ndiff++;
    lb = '0;
    if (obs.size() > 0) lb = obs[obs.size() - 1];
  endtask

  task automatic test_reset();
    rst = 1'b1; crs = 1'b1; rxd = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (all_outputs() !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_outputs());
    end
    rst = 1'b0; crs = 1'b0; rxd = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (all_outputs() !== '0) begin
      bad++; $display("FAIL idle_outputs: got %h want 0", all_outputs());
    end
  endtask

  task automatic test_good();
    int unsigned nd; beat_t lb;
    clear(); make_frame(64, -1); model(64, 0); send(64, 0, 12); analyze('1, nd, lb);
    total++; if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL good_beats: got %0d want %0d", obs.size(), exp_q.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL good_data: got %0d bad beats want 0", nd); end
    total++; if ({lb.eop, lb.crc, lb.runt, lb.giant, lb.align} !== 5'b10000) begin bad++; $display("FAIL good_eop_flags: got %b want 10000", {lb.eop, lb.crc, lb.runt, lb.giant, lb.align}); end
    total++; if (obs_cyc.size() == 0 || obs_cyc[obs_cyc.size()-1] !== drop_cyc) begin bad++; $display("FAIL good_eop_latency: got %0d want cycle %0d", (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] : 0, drop_cyc); end
  endtask

  task automatic test_crc_err();
    int unsigned nd; beat_t lb;
    clear(); make_frame(64, 19); model(64, 0); send(64, 0, 12); analyze('1, nd, lb);
    total++; if (obs.size() !== 64) begin bad++; $display("FAIL crc_beats: got %0d want 64", obs.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL crc_data: got %0d bad beats want 0", nd); end
    total++; if ({lb.eop, lb.crc, lb.runt, lb.giant, lb.align} !== 5'b11000) begin bad++; $display("FAIL crc_eop_flags: got %b want 11000", {lb.eop, lb.crc, lb.runt, lb.giant, lb.align}); end
  endtask

  task automatic test_runt();
    int unsigned nd; beat_t lb;
    clear(); make_frame(60, -1); model(60, 0); send(60, 0, 12); analyze('1, nd, lb);
    total++; if (obs.size() !== 60) begin bad++; $display("FAIL runt_beats: got %0d want 60", obs.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL runt_data: got %0d bad beats want 0", nd); end
    total++; if ({lb.eop, lb.crc, lb.runt, lb.giant, lb.align} !== 5'b10100) begin bad++; $display("FAIL runt_eop_flags: got %b want 10100", {lb.eop, lb.crc, lb.runt, lb.giant, lb.align}); end
  endtask

  task automatic test_giant();
    int unsigned nd; beat_t lb;
    clear(); make_frame(1530, -1); model(1530, 0); send(1530, 0, 12); analyze('1, nd, lb);
    total++; if (obs.size() !== MAXB) begin bad++; $display("FAIL giant_beats: got %0d want %0d", obs.size(), MAXB); end
    total++; if (nd !== 0) begin bad++; $display("FAIL giant_data: got %0d bad beats want 0", nd); end
    total++; if ({lb.eop, lb.crc, lb.runt, lb.giant, lb.align} !== 5'b10010) begin bad++; $display("FAIL giant_eop_flags: got %b want 10010", {lb.eop, lb.crc, lb.runt, lb.giant, lb.align}); end
  endtask

  task automatic test_align();
    int unsigned nd; beat_t lb; beat_t mask;
    mask = '1; mask.crc = 1'b0;
    clear(); make_frame(64, -1); model(64, 2); send(64, 2, 12); analyze(mask, nd, lb);
    total++; if (obs.size() !== 64) begin bad++; $display("FAIL align_beats: got %0d want 64", obs.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL align_data: got %0d bad beats want 0", nd); end
    total++; if ({lb.eop, lb.runt, lb.giant, lb.align} !== 4'b1001) begin bad++; $display("FAIL align_eop_flags: got %b want 1001", {lb.eop, lb.runt, lb.giant, lb.align}); end
  endtask

  task automatic test_false_carrier();
    int unsigned nd; beat_t lb;
    clear();
    put(1'b1, 2'b01); put(1'b1, 2'b01); put(1'b1, 2'b10);
    for (int unsigned i = 0; i < 6; i++) put(1'b1, 2'($urandom));
    put_gap(8);
    total++; if (obs.size() !== 0) begin bad++; $display("FAIL false_carrier_beats: got %0d want 0", obs.size()); end
    clear(); make_frame(70, -1); model(70, 0); send(70, 0, 12); analyze('1, nd, lb);
    total++; if (obs.size() !== 70) begin bad++; $display("FAIL after_false_beats: got %0d want 70", obs.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL after_false_data: got %0d bad beats want 0", nd); end
  endtask

  task automatic test_zero_one();
    int unsigned nd; beat_t lb;
    clear(); put_preamble(); put_gap(8);
    total++; if (obs.size() !== 0) begin bad++; $display("FAIL zero_byte_beats: got %0d want 0", obs.size()); end
    clear(); frame.delete(); frame.push_back(8'h00); model(1, 0);
    put_preamble(); put_byte(8'h00); put_gap(8); analyze('1, nd, lb);
    total++; if (obs.size() !== 1) begin bad++; $display("FAIL one_byte_beats: got %0d want 1", obs.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL one_byte_beat: got %0d bad beats want 0", nd); end
    total++; if ({lb.sop, lb.eop, lb.runt} !== 3'b111) begin bad++; $display("FAIL one_byte_flags: got %b want 111", {lb.sop, lb.eop, lb.runt}); end
  endtask

  task automatic test_back_to_back();
    int unsigned nd; beat_t lb; int unsigned n; int corrupt;
    clear();
    for (int unsigned f = 0; f < 6; f++) begin
      n       = $urandom_range(90, 8);
      corrupt = ($urandom_range(2, 0) == 0) ? int'($urandom_range(n - 5, 0)) : -1;
      make_frame(n, corrupt);
      model(n, 0);
      send(n, 0, (f == 5) ? 12 : $urandom_range(4, 1));
    end
    analyze('1, nd, lb);
    total++; if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_beats: got %0d want %0d", obs.size(), exp_q.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL b2b_data: got %0d bad beats want 0", nd); end
  endtask

  task automatic test_10m();
    int unsigned nd; beat_t lb; int unsigned viol;
    speed_100 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    clear(); make_frame(64, -1); model(64, 0); send(64, 0, 4); analyze('1, nd, lb);
    viol = 0;
    for (int unsigned i = 1; i + 1 < obs_cyc.size(); i++)
      if (obs_cyc[i] - obs_cyc[i-1] != 40) viol++;
    total++; if (obs.size() !== 64) begin bad++; $display("FAIL m10_beats: got %0d want 64", obs.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL m10_data: got %0d bad beats want 0", nd); end
    total++; if (viol !== 0) begin bad++; $display("FAIL m10_spacing: got %0d gaps not 40 cycles want 0", viol); end
  endtask

  task automatic test_reset_mid();
    int unsigned nd; beat_t lb; int unsigned neop; beat_t b;
    clear(); make_frame(64, -1);
    put_preamble();
    for (int unsigned i = 0; i < 29; i++) put_byte(frame[i]);
    rst = 1'b1; crs = 1'b1; rxd = 2'b10;
    @(posedge clk);
    #1;
    total++; if (all_outputs() !== '0) begin bad++; $display("FAIL midreset_outputs: got %h want 0", all_outputs()); end
    rst = 1'b0;
    for (int unsigned i = 0; i < 35; i++) put_byte(8'hAA);
    put_gap(6);
    for (int unsigned i = 0; i < 28; i++) begin
      b = '0; b.data = frame[i]; b.sop = (i == 0); exp_q.push_back(b);
    end
    analyze('1, nd, lb);
    neop = 0;
    foreach (obs[i]) if (obs[i].eop) neop++;
    total++; if (obs.size() !== 28) begin bad++; $display("FAIL midreset_beats: got %0d want 28", obs.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL midreset_data: got %0d bad beats want 0", nd); end
    total++; if (neop !== 0) begin bad++; $display("FAIL midreset_eop: got %0d eop beats want 0", neop); end
    clear(); make_frame(64, -1); model(64, 0); send(64, 0, 4); analyze('1, nd, lb);
    total++; if (obs.size() !== 64) begin bad++; $display("FAIL postreset_beats: got %0d want 64", obs.size()); end
    total++; if (nd !== 0) begin bad++; $display("FAIL postreset_data: got %0d bad beats want 0", nd); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_good();
    test_crc_err();
    test_runt();
    test_giant();
    test_align();
    test_false_carrier();
    test_zero_one();
    test_back_to_back();
    test_10m();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
